iomem_arbiter: RTL and testbench

Two-master round-robin arbiter that shares the single SoC `iomem` slave port between the PicoRV32 core's `iomem` master and a second master, such as a UART debug bridge or DMA engine. It sits between the requesters and the `iomem` address decoder/peripherals (GPIO at `0x03xx_xxxx`). It holds a grant for exactly one complete transfer. An optional watchdog terminates transfers that a slave never acknowledges.

---
 rtl/iomem_arbiter_if.sv | 20 ++
 rtl/iomem_arbiter.sv | 139 +++++++++++++
 tb/tb_iomem_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_arbiter_if.sv
// PicoRV32-style iomem bus: valid/wstrb/addr/wdata request, ready/rdata completion.
// The master modport issues requests and the slave modport answers them.
interface iomem_arbiter_if;
  logic        valid;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output valid, wstrb, addr, wdata,
    input  ready, rdata
  );

  modport slave (
    input  valid, wstrb, addr, wdata,
    output ready, rdata
  );
endinterface

// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter onto one iomem slave port; holds the grant for one transfer.
// Optional watchdog enabled by defining IOMEM_ARB_TIMEOUT_EN.
module iomem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_DATA       = 32'hBAD0_BAD0
) (
  input  logic            clk,
  input  logic            resetn,
  iomem_arbiter_if.slave  m0,
  iomem_arbiter_if.slave  m1,
  iomem_arbiter_if.master s,
  output logic            owner,
  output logic            timeout_err
);

  typedef enum logic {StIdle = 1'b0, StBusy = 1'b1} state_e;

  state_e      r_state, w_state_d;
  logic        r_owner, w_owner_d;
  logic        r_rr_last, w_rr_last_d;
  logic        w_grant;
  logic        w_busy;
  logic        w_done;
  logic        w_timeout;
  logic [31:0] w_rdata;

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam logic [7:0] WdogLast = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] r_wdog, w_wdog_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_wdog <= 8'd0;
    end else begin
      r_wdog <= w_wdog_d;
    end
  end
`else
  logic w_unused_params;
  assign w_unused_params = ^{ERR_DATA, 8'(TIMEOUT_CYCLES)};
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= StIdle;
      r_owner   <= 1'b0;
      r_rr_last <= 1'b1;
    end else begin
      r_state   <= w_state_d;
      r_owner   <= w_owner_d;
      r_rr_last <= w_rr_last_d;
    end
  end

  // A lone requester always wins; round-robin only breaks ties.
  assign w_grant = (m0.valid && m1.valid) ? ~r_rr_last : m1.valid;

  // Gating on resetn keeps an aborted transfer from completing in the reset cycle.
  assign w_busy = resetn && (r_state == StBusy);

  always_comb begin
    w_state_d   = r_state;
    w_owner_d   = r_owner;
    w_rr_last_d = r_rr_last;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    w_rdata     = s.rdata;
`ifdef IOMEM_ARB_TIMEOUT_EN
    w_wdog_d    = r_wdog;
`endif
    case (r_state)
      StIdle: begin
        if (m0.valid || m1.valid) begin
          w_state_d = StBusy;
          w_owner_d = w_grant;
`ifdef IOMEM_ARB_TIMEOUT_EN
          w_wdog_d  = 8'd0;
`endif
        end
      end
      StBusy: begin
        if (s.ready) begin
          w_done = 1'b1;
`ifdef IOMEM_ARB_TIMEOUT_EN
        end else if (r_wdog == WdogLast) begin
          w_done    = 1'b1;
          w_timeout = 1'b1;
          w_rdata   = ERR_DATA;
        end else begin
          w_wdog_d = r_wdog + 8'd1;
`endif
        end
        if (w_done) begin
          w_state_d   = StIdle;
          w_rr_last_d = r_owner;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    s.valid     = 1'b0;
    s.wstrb     = 4'd0;
    s.addr      = 32'd0;
    s.wdata     = 32'd0;
    m0.ready    = 1'b0;
    m0.rdata    = 32'd0;
    m1.ready    = 1'b0;
    m1.rdata    = 32'd0;
    timeout_err = 1'b0;
    if (w_busy) begin
      s.valid = 1'b1;
      if (r_owner) begin
        s.wstrb = m1.wstrb;
        s.addr  = m1.addr;
        s.wdata = m1.wdata;
      end else begin
        s.wstrb = m0.wstrb;
        s.addr  = m0.addr;
        s.wdata = m0.wdata;
      end
      if (w_done) begin
        timeout_err = w_timeout;
        if (r_owner) begin
          m1.ready = 1'b1;
          m1.rdata = w_rdata;
        end else begin
          m0.ready = 1'b1;
          m0.rdata = w_rdata;
        end
      end
    end
  end

  assign owner = r_owner;

endmodule

// File: tb/tb_iomem_arbiter.sv
// Self-checking bench for iomem_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level model of grants and completions.
module tb_iomem_arbiter;

  logic clk = 1'b0;
  logic resetn;
  logic owner;
  logic timeout_err;

  always #5 clk = ~clk;

  iomem_arbiter_if m0_if ();
  iomem_arbiter_if m1_if ();
  iomem_arbiter_if s_if ();

  iomem_arbiter #(
    .TIMEOUT_CYCLES(4),
    .ERR_DATA      (32'hBAD0_BAD0)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .m0         (m0_if),
    .m1         (m1_if),
    .s          (s_if),
    .owner      (owner),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int errors = 0;

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_if.valid = 1'b0; m0_if.wstrb = 4'd0; m0_if.addr = 32'd0; m0_if.wdata = 32'd0;
    m1_if.valid = 1'b0; m1_if.wstrb = 4'd0; m1_if.addr = 32'd0; m1_if.wdata = 32'd0;
    s_if.ready  = 1'b0; s_if.rdata  = 32'd0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    clear_inputs();
    step();
    step();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if ({s_if.valid, m0_if.ready, m1_if.ready, timeout_err, owner} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 00000",
               {s_if.valid, m0_if.ready, m1_if.ready, timeout_err, owner});
    end
    checks++;
    if ({s_if.wstrb, s_if.addr, s_if.wdata} !== 68'd0) begin
      errors++;
      $display("FAIL reset_bus: got %h required 0", {s_if.wstrb, s_if.addr, s_if.wdata});
    end
    step();
  endtask

  task automatic test_m0_read();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0300_0000; m0_if.wstrb = 4'd0;
    @(negedge clk);
    checks++;
    if (s_if.valid !== 1'b0) begin
      errors++; $display("FAIL read_c0_svalid: got %b required 0", s_if.valid);
    end
    step();
    @(negedge clk);
    checks++;
    if ({s_if.valid, s_if.addr, m0_if.ready} !== {1'b1, 32'h0300_0000, 1'b0}) begin
      errors++;
      $display("FAIL read_c1: got v=%b a=%h r=%b required v=1 a=03000000 r=0",
               s_if.valid, s_if.addr, m0_if.ready);
    end
    step();
    s_if.ready = 1'b1; s_if.rdata = 32'h0000_00A5;
    @(negedge clk);
    checks++;
    if ({s_if.valid, m0_if.ready, m0_if.rdata, m1_if.ready, m1_if.rdata} !==
        {1'b1, 1'b1, 32'h0000_00A5, 1'b0, 32'd0}) begin
      errors++;
      $display("FAIL read_c2: got v=%b r0=%b d0=%h r1=%b d1=%h required v=1 r0=1 d0=a5 r1=0 d1=0",
               s_if.valid, m0_if.ready, m0_if.rdata, m1_if.ready, m1_if.rdata);
    end
    step();
    clear_inputs();
    @(negedge clk);
    checks++;
    if ({s_if.valid, m0_if.ready} !== 2'b00) begin
      errors++; $display("FAIL read_c3_idle: got %b required 00", {s_if.valid, m0_if.ready});
    end
    step();
  endtask

  task automatic test_m1_write();
    m1_if.valid = 1'b1; m1_if.addr = 32'h0300_0004; m1_if.wstrb = 4'b0001;
    m1_if.wdata = 32'h0000_003C;
    step();
    s_if.ready = 1'b1; s_if.rdata = 32'h1357_9BDF;
    @(negedge clk);
    checks++;
    if ({s_if.valid, s_if.wstrb, s_if.wdata, s_if.addr} !==
        {1'b1, 4'b0001, 32'h0000_003C, 32'h0300_0004}) begin
      errors++;
      $display("FAIL write_bus: got v=%b s=%b d=%h a=%h required v=1 s=0001 d=3c a=03000004",
               s_if.valid, s_if.wstrb, s_if.wdata, s_if.addr);
    end
    checks++;
    if ({m1_if.ready, m1_if.rdata, m0_if.ready, owner} !== {1'b1, 32'h1357_9BDF, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL write_ready: got r1=%b d1=%h r0=%b own=%b required 1 13579bdf 0 1",
               m1_if.ready, m1_if.rdata, m0_if.ready, owner);
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_tie();
    do_reset();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0300_0010;
    m1_if.valid = 1'b1; m1_if.addr = 32'h0300_0020;
    step();
    s_if.ready = 1'b1; s_if.rdata = 32'h11;
    @(negedge clk);
    checks++;
    if ({owner, s_if.addr, m0_if.ready, m1_if.ready} !== {1'b0, 32'h0300_0010, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL tie_first: got own=%b a=%h r0=%b r1=%b required 0 03000010 1 0",
               owner, s_if.addr, m0_if.ready, m1_if.ready);
    end
    step();
    m0_if.valid = 1'b0; s_if.ready = 1'b0;
    @(negedge clk);
    checks++;
    if (s_if.valid !== 1'b0) begin
      errors++; $display("FAIL tie_gap: got s_valid=%b required 0", s_if.valid);
    end
    step();
    s_if.ready = 1'b1; s_if.rdata = 32'h22;
    @(negedge clk);
    checks++;
    if ({s_if.valid, owner, s_if.addr, m1_if.ready, m1_if.rdata, m0_if.ready} !==
        {1'b1, 1'b1, 32'h0300_0020, 1'b1, 32'h22, 1'b0}) begin
      errors++;
      $display("FAIL tie_second: got v=%b own=%b a=%h r1=%b d1=%h r0=%b required 1 1 03000020 1 22 0",
               s_if.valid, owner, s_if.addr, m1_if.ready, m1_if.rdata, m0_if.ready);
    end
    step();
    s_if.ready = 1'b0; m0_if.valid = 1'b1;
    step();
    s_if.ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({owner, m0_if.ready, m1_if.ready} !== 3'b010) begin
      errors++;
      $display("FAIL tie_repeat: got own=%b r0=%b r1=%b required 0 1 0",
               owner, m0_if.ready, m1_if.ready);
    end
    step();
    clear_inputs();
    step();
  endtask

  task automatic test_reset_mid_busy();
    m0_if.valid = 1'b1; m0_if.addr = 32'h0300_0030;
    step();
    m1_if.valid = 1'b1; m1_if.addr = 32'h0300_0040;
    @(negedge clk);
    checks++;
    if ({s_if.valid, owner} !== 2'b10) begin
      errors++; $display("FAIL rst_busy_pre: got %b required 10", {s_if.valid, owner});
    end
    step();
    resetn = 1'b0; m0_if.valid = 1'b0;
    step();
    resetn = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_if.valid, m0_if.ready, m1_if.ready} !== 3'b000) begin
      errors++;
      $display("FAIL rst_busy_after: got %b required 000", {s_if.valid, m0_if.ready, m1_if.ready});
    end
    step();
    s_if.ready = 1'b1; s_if.rdata = 32'h44;
    @(negedge clk);
    checks++;
    if ({s_if.valid, owner, s_if.addr, m1_if.ready, m0_if.ready} !==
        {1'b1, 1'b1, 32'h0300_0040, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL rst_busy_regrant: got v=%b own=%b a=%h r1=%b r0=%b required 1 1 03000040 1 0",
               s_if.valid, owner, s_if.addr, m1_if.ready, m0_if.ready);
    end
    step();
    clear_inputs();
    step();
  endtask

`ifdef IOMEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      m0_if.valid = 1'b1; m0_if.addr = 32'h0300_0050;
      step();
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        checks++;
        if ({s_if.valid, m0_if.ready, timeout_err} !== 3'b100) begin
          errors++;
          $display("FAIL wdog_wait c%0d: got %b required 100", c,
                   {s_if.valid, m0_if.ready, timeout_err});
        end
        step();
      end
      if (pass == 1) begin
        s_if.ready = 1'b1; s_if.rdata = 32'h0000_1234;
      end
      @(negedge clk);
      checks++;
      if (pass == 0 && {m0_if.ready, m0_if.rdata, timeout_err} !== {1'b1, 32'hBAD0_BAD0, 1'b1}) begin
        errors++;
        $display("FAIL wdog_expire: got r=%b d=%h t=%b required 1 bad0bad0 1",
                 m0_if.ready, m0_if.rdata, timeout_err);
      end
      if (pass == 1 && {m0_if.ready, m0_if.rdata, timeout_err} !== {1'b1, 32'h0000_1234, 1'b0}) begin
        errors++;
        $display("FAIL wdog_race: got r=%b d=%h t=%b required 1 00001234 0",
                 m0_if.ready, m0_if.rdata, timeout_err);
      end
      step();
      clear_inputs();
      @(negedge clk);
      checks++;
      if (s_if.valid !== 1'b0) begin
        errors++; $display("FAIL wdog_idle: got s_valid=%b required 0", s_if.valid);
      end
      step();
    end
  endtask
`else
  task automatic test_no_timeout();
    int bad = 0;
    m0_if.valid = 1'b1; m0_if.addr = 32'h0300_0060;
    step();
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if ({s_if.valid, m0_if.ready, m1_if.ready, timeout_err} !== 4'b1000) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL no_wdog_hold: got %0d bad cycles required 0", bad);
    end
    s_if.ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m0_if.ready !== 1'b1) begin
      errors++; $display("FAIL no_wdog_release: got m0_ready=%b required 1", m0_if.ready);
    end
    step();
    clear_inputs();
    step();
  endtask
`endif

  // Transaction model: pending requests per master, who is being served, who was served last.
  task automatic test_random();
    bit          req_v[2];
    logic [3:0]  req_ws[2];
    logic [31:0] req_ad[2];
    logic [31:0] req_wd[2];
    bit          mbusy = 0;
    int          cur = 0;
    int          last = 1;
    int          blen = 0;
    bit          ack;
    logic [31:0] rd;
    logic [32:0] exp0, exp1;
    do_reset();
    for (int i = 0; i < 2; i++) req_v[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!req_v[i] && $urandom_range(1, 0) == 1) begin
          req_v[i]  = 1;
          req_ws[i] = 4'($urandom);
          req_ad[i] = $urandom;
          req_wd[i] = $urandom;
        end
      end
      m0_if.valid = req_v[0]; m0_if.wstrb = req_ws[0]; m0_if.addr = req_ad[0]; m0_if.wdata = req_wd[0];
      m1_if.valid = req_v[1]; m1_if.wstrb = req_ws[1]; m1_if.addr = req_ad[1]; m1_if.wdata = req_wd[1];
      ack = mbusy && (blen == 2 || $urandom_range(2, 0) == 0);
      rd  = $urandom;
      s_if.ready = ack; s_if.rdata = rd;
      @(negedge clk);
      exp0 = (ack && cur == 0) ? {1'b1, rd} : 33'd0;
      exp1 = (ack && cur == 1) ? {1'b1, rd} : 33'd0;
      checks++;
      if (mbusy && {s_if.valid, s_if.wstrb, s_if.addr, s_if.wdata, owner} !==
          {1'b1, req_ws[cur], req_ad[cur], req_wd[cur], cur[0]}) begin
        errors++;
        $display("FAIL rand_bus cyc%0d: got v=%b s=%h a=%h d=%h own=%b required v=1 s=%h a=%h d=%h own=%0d",
                 cyc, s_if.valid, s_if.wstrb, s_if.addr, s_if.wdata, owner,
                 req_ws[cur], req_ad[cur], req_wd[cur], cur);
      end
      if (!mbusy && {s_if.valid, s_if.wstrb, s_if.addr, s_if.wdata, owner} !==
          {69'd0, cur[0]}) begin
        errors++;
        $display("FAIL rand_idle cyc%0d: got v=%b s=%h a=%h d=%h own=%b required zeros own=%0d",
                 cyc, s_if.valid, s_if.wstrb, s_if.addr, s_if.wdata, owner, cur);
      end
      checks++;
      if ({m0_if.ready, m0_if.rdata, m1_if.ready, m1_if.rdata, timeout_err} !== {exp0, exp1, 1'b0}) begin
        errors++;
        $display("FAIL rand_ready cyc%0d: got r0=%b d0=%h r1=%b d1=%h t=%b required %h %h t=0",
                 cyc, m0_if.ready, m0_if.rdata, m1_if.ready, m1_if.rdata, timeout_err, exp0, exp1);
      end
      if (mbusy) begin
        if (ack) begin
          mbusy = 0; last = cur; req_v[cur] = 0;
        end else begin
          blen++;
        end
      end else if (req_v[0] || req_v[1]) begin
        cur   = (req_v[0] && req_v[1]) ? 1 - last : (req_v[1] ? 1 : 0);
        mbusy = 1;
        blen  = 0;
      end
      step();
    end
    clear_inputs();
    step();
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    step();
    test_reset();
    test_m0_read();
    test_m1_write();
    test_tie();
    test_reset_mid_busy();
`ifdef IOMEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
